// File: rtl/sigmoid_pipe.sv
// -----------------------------------------------------------------------------
// sigmoid_pipe
// Three-stage piecewise-linear (PLAN) sigmoid activation stage. It takes the
// signed Q8.8 pre-activation sum from the ALU array and returns the unsigned
// Q8.8 activation (0..256) to the write-back path.
//
//   Stage 1: sign, saturated magnitude, region select
//   Stage 2: magnitude result y (piecewise-linear segment, floor shifts)
//   Stage 3: reflect around 0.5 for negative inputs, registered outputs
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [15:0] signed Q8.8 pre-activation
//   in_valid   in   in_data valid
//   in_ready   out  block accepts in_data this cycle (combinational from out_ready)
//   out_data   out  [15:0] unsigned Q8.8 sigmoid result, 0..256
//   out_valid  out  out_data valid
//   out_ready  in   consumer accepts out_data
//   busy       out  any pipeline stage holds a valid sample
//   deriv_out  out  [15:0] unsigned Q8.8 derivative y*(256-y)>>8
//                   (present only when SIGMOID_DERIV_EN is defined)
//
// Optional feature macro: SIGMOID_DERIV_EN
// -----------------------------------------------------------------------------
module sigmoid_pipe #(
    parameter int DATA_W = 16,
    parameter int SAT_HI = 1280,
    parameter int MID_HI = 608,
    parameter int LIN_HI = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef SIGMOID_DERIV_EN
    output logic [DATA_W-1:0] deriv_out,
`endif
    output logic              busy
);

    localparam logic [15:0] L_SAT = SAT_HI[15:0];
    localparam logic [15:0] L_MID = MID_HI[15:0];
    localparam logic [15:0] L_LIN = LIN_HI[15:0];

    // Region encoding: 0 = R1 (linear core) ... 3 = R4 (saturated)
    localparam logic [1:0] REG_R1 = 2'd0;
    localparam logic [1:0] REG_R2 = 2'd1;
    localparam logic [1:0] REG_R3 = 2'd2;
    localparam logic [1:0] REG_R4 = 2'd3;

    logic        w_adv;
    logic [15:0] w_neg;
    logic [15:0] w_mag;
    logic [1:0]  w_region;
    logic [15:0] w_y_wide;
    logic [8:0]  w_refl;

    logic        r_v1;
    logic        r_sign1;
    logic [14:0] r_mag1;
    logic [1:0]  r_reg1;

    logic        r_v2;
    logic        r_sign2;
    logic [8:0]  r_y2;

    logic        r_v3;
    logic [15:0] r_out;

    // Whole pipeline moves together whenever the output slot is free or draining
    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign out_data  = r_out;
    assign busy      = r_v1 || r_v2 || r_v3;
    assign w_neg     = 16'd0 - in_data;

    // Stage 1 combinational: saturated magnitude (-32768 has no positive twin)
    always_comb begin
        w_mag = in_data;
        if (in_data == 16'h8000) begin
            w_mag = 16'h7FFF;
        end else if (in_data[15]) begin
            w_mag = w_neg;
        end else begin
            w_mag = in_data;
        end
    end

    // Stage 1 combinational: region select, thresholds inclusive on the upper region
    always_comb begin
        w_region = REG_R1;
        if (w_mag >= L_SAT) begin
            w_region = REG_R4;
        end else if (w_mag >= L_MID) begin
            w_region = REG_R3;
        end else if (w_mag >= L_LIN) begin
            w_region = REG_R2;
        end else begin
            w_region = REG_R1;
        end
    end

    // Stage 1 registers: sign, magnitude, region
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_mag1  <= 15'd0;
            r_reg1  <= REG_R1;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_sign1 <= in_data[15];
            r_mag1  <= w_mag[14:0];
            r_reg1  <= w_region;
        end
    end

    // Stage 2 combinational: per-region line segment; every result fits in 9 bits
    always_comb begin
        w_y_wide = 16'd0;
        case (r_reg1)
            REG_R1:  w_y_wide = ({1'b0, r_mag1} >> 2) + 16'd128;
            REG_R2:  w_y_wide = ({1'b0, r_mag1} >> 3) + 16'd160;
            REG_R3:  w_y_wide = ({1'b0, r_mag1} >> 5) + 16'd216;
            REG_R4:  w_y_wide = 16'd256;
            default: w_y_wide = 16'd256;
        endcase
    end

    // Stage 2 registers: magnitude result and carried sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_sign2 <= 1'b0;
            r_y2    <= 9'd0;
        end else if (w_adv) begin
            r_v2    <= r_v1;
            r_sign2 <= r_sign1;
            r_y2    <= w_y_wide[8:0];
        end
    end

    // Stage 3 combinational: sigmoid(-x) = 1 - sigmoid(x)
    always_comb begin
        w_refl = r_y2;
        if (r_sign2) begin
            w_refl = 9'd256 - r_y2;
        end else begin
            w_refl = r_y2;
        end
    end

    // Stage 3 registers: output slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3  <= 1'b0;
            r_out <= 16'd0;
        end else if (w_adv) begin
            r_v3  <= r_v2;
            r_out <= {7'd0, w_refl};
        end
    end

`ifdef SIGMOID_DERIV_EN
    logic [17:0] w_prod;
    logic [15:0] r_deriv;

    // Derivative uses the unreflected y: y(256-y) is symmetric in the sign
    assign w_prod    = {9'd0, r_y2} * {9'd0, (9'd256 - r_y2)};
    assign deriv_out = r_deriv;

    // Stage 3 derivative register, same advance rule as out_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deriv <= 16'd0;
        end else if (w_adv) begin
            r_deriv <= {6'd0, w_prod[17:8]};
        end
    end
`endif

endmodule

// File: tb/tb_sigmoid_pipe.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_pipe
// Scoreboard bench for sigmoid_pipe: expected results are queued when a sample
// is accepted and compared when the DUT transfers an output.
// -----------------------------------------------------------------------------
module tb_sigmoid_pipe;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
`ifdef SIGMOID_DERIV_EN
    logic [15:0] deriv_out;
`endif

    sigmoid_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SIGMOID_DERIV_EN
        .deriv_out (deriv_out),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] d;
        logic [15:0] dv;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        lat_chk  = 1'b0;
    logic        was_stall = 1'b0;
    logic [15:0] hold_data = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference sigmoid and derivative, written straight from the PLAN definition
    function automatic logic [15:0] model(input logic [15:0] x, output logic [15:0] dv);
        int xi, mag, y;
        xi  = int'($signed(x));
        mag = (xi < 0) ? -xi : xi;
        if (mag > 32767) mag = 32767;
        if (mag >= 1280)     y = 256;
        else if (mag >= 608) y = (mag >> 5) + 216;
        else if (mag >= 256) y = (mag >> 3) + 160;
        else                 y = (mag >> 2) + 128;
        dv = 16'((y * (256 - y)) >> 8);
        return (xi < 0) ? 16'(256 - y) : 16'(y);
    endfunction

    // One clock cycle: drive, sample at negedge+1, score, then advance
    task automatic step(input logic v, input logic [15:0] d, input logic ordy,
                        input logic [15:0] exp_d, output logic acc);
        exp_t        e;
        logic [15:0] dv;
        logic [15:0] dummy;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        check_eq("busy", 32'(busy), 32'(sb_q.size() != 0));
        check_eq("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (was_stall) check_eq("stall_hold", 32'(out_data), 32'(hold_data));
        was_stall = out_valid && !out_ready;
        hold_data = out_data;
        if (sb_q.size() == 0) begin
            check_eq("idle_out_valid", 32'(out_valid), 32'd0);
        end else if (out_valid && out_ready) begin
            e = sb_q.pop_front();
            check_eq("out_data", 32'(out_data), 32'(e.d));
`ifdef SIGMOID_DERIV_EN
            check_eq("deriv_out", 32'(deriv_out), 32'(e.dv));
`endif
            if (lat_chk) check_eq("latency", 32'(cyc - e.cyc), 32'd3);
        end
        acc = v && in_ready;
        if (acc) begin
            dummy = model(d, dv);
            e.d   = exp_d;
            e.dv  = dv;
            e.cyc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(1'b0, 16'd0, 1'b1, 16'd0, acc);
        check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
        step(1'b0, 16'd0, 1'b1, 16'd0, acc);
    endtask

    logic [15:0] pt_in  [12] = '{16'd0, 16'd256, 16'hFF00, 16'd512, 16'd608, 16'd2000, 16'h8000,
                                 16'd255, 16'd256, 16'd607, 16'd1279, 16'd1280};
    logic [15:0] pt_exp [12] = '{16'd128, 16'd192, 16'd64, 16'd224, 16'd235, 16'd256, 16'd0,
                                 16'd191, 16'd192, 16'd235, 16'd255, 16'd256};

    initial begin
        logic        acc;
        logic [15:0] dv;
        logic [15:0] bp_in [6];
        int          idx, stall;
        logic        started, pv;
        logic [15:0] pd;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SIGMOID_DERIV_EN
        check_eq("rst_deriv", 32'(deriv_out), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Point values and region boundaries, back to back, no stall
        lat_chk = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, pt_in[i], 1'b1, pt_exp[i], acc);
        drain();

        // Bubbles: valid 1,0,1,0
        for (int i = 0; i < 4; i++)
            step(i[0] ? 1'b0 : 1'b1, 16'd300 + 16'(i), 1'b1, model(16'd300 + 16'(i), dv), acc);
        drain();
        lat_chk = 1'b0;

        // Back-pressure: 4-cycle stall after the first output, upstream holds its sample
        for (int i = 0; i < 6; i++) bp_in[i] = 16'($urandom);
        idx = 0; stall = 0; started = 1'b0;
        for (int i = 0; i < 40 && (idx < 6 || sb_q.size() != 0); i++) begin
            if (!started && out_valid) begin started = 1'b1; stall = 4; end
            if (idx < 6) step(1'b1, bp_in[idx], (stall > 0) ? 1'b0 : 1'b1, model(bp_in[idx], dv), acc);
            else         step(1'b0, 16'd0, (stall > 0) ? 1'b0 : 1'b1, 16'd0, acc);
            if (acc) idx++;
            if (stall > 0) stall--;
        end
        check_eq("bp_all_sent", 32'(idx), 32'd6);
        drain();

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) step(1'b1, 16'd100 * 16'(i + 1), 1'b0, model(16'd100 * 16'(i + 1), dv), acc);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_out_data", 32'(out_data), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        sb_q.delete();
        was_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 1'b1, 16'd0, acc);

        // Random traffic with random back-pressure
        pv = 1'b0; pd = 16'd0;
        for (int i = 0; i < 80; i++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pd = 16'($urandom);
            end
            step(pv, pd, ($urandom_range(0, 3) != 0), model(pd, dv), acc);
            if (acc) pv = 1'b0;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sigmoid_pipe.md
Name: sigmoid_pipe

Overview:
- Pipelined piecewise-linear (PLAN) sigmoid activation stage.
- Sits directly downstream of the ALU cell array: consumes the ALU's to_sigmoid result (the neuron pre-activation sum) and returns the activation to the memory/write-back path.
- 3-stage pipeline with valid/ready handshake on both sides, accepting one sample per cycle when not stalled.
- All data is signed/unsigned Q8.8 fixed point, 16 bits.

Parameters:
- DATA_W, 16, data width. Fixed Q8.8; only 16 is supported.
- SAT_HI, 1280, |x| threshold of region 4 (5.0 in Q8.8).
- MID_HI, 608, |x| threshold of region 3 (2.375 in Q8.8).
- LIN_HI, 256, |x| threshold of region 2 (1.0 in Q8.8).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  16  signed Q8.8 pre-activation (ALU to_sigmoid)
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- out_data  out  16  unsigned Q8.8 sigmoid result, range 0..256
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- busy  out  1  any pipeline stage holds a valid sample

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0, all stage valid bits clear, out_data=0, out_valid=0, busy=0. in_ready=1 after reset.
- Reset asserted mid-operation: all in-flight samples are discarded; nothing is emitted after release.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - adv = !out_valid || out_ready. All stages advance only when adv=1.
  - in_ready = adv (combinational from out_ready).
  - Held samples and out_data are stable while stalled.
  - Bubbles propagate: a stage valid bit loads the previous stage valid bit on adv.
- Latency: 3 cycles from accepted input to out_valid, with no stall. Throughput is 1 sample per cycle.
- Stage 1 (abs/region):
  - sign = in_data[15].
  - mag = |in_data|; for in_data = -32768, mag = 32767 (saturate).
  - region: mag >= SAT_HI -> R4; mag >= MID_HI -> R3; mag >= LIN_HI -> R2; else R1. Thresholds are inclusive at the lower bound of each higher region.
- Stage 2 (magnitude result y, unsigned, floor shifts):
  - R1: y = (mag>>2) + 128
  - R2: y = (mag>>3) + 160
  - R3: y = (mag>>5) + 216
  - R4: y = 256
  - y never exceeds 256 (9 bits suffice); sign is carried along.
- Stage 3 (reflect): out_data = sign ? (256 - y) : y, zero-extended to 16 bits.
- busy = OR of all stage valid bits.
- Simultaneous input accept and output drain in the same cycle is a normal advance; no data loss or duplication.
- in_valid while in_ready=0: the sample is not taken; the upstream holds it.

Optional Feature:
- Macro: SIGMOID_DERIV_EN
- Defined:
  - Adds output port deriv_out (16, out): unsigned Q8.8 derivative, (y*(256-y))>>8, computed from the stage-2 magnitude y and registered in stage 3 alongside out_data.
  - Sign-independent, since s(1-s) is symmetric.
  - Same valid/stall/reset rules as out_data; reset value 0; maximum value 64.
- Undefined: port and logic absent. Behaviour of all other ports is identical.

Test Plan:
- Point values, one per cycle, out_ready=1: in_data 0 -> 128; 256 -> 192; -256 -> 64; 512 -> 224; 608 -> 235; 2000 -> 256; -32768 -> 0. Each appears exactly 3 cycles after acceptance, in order.
- Region boundaries: 255 -> 191; 256 -> 192; 607 -> 235; 1279 -> 255; 1280 -> 256. Verifies inclusive thresholds and floor rounding.
- Back-pressure:
  - Stream 6 samples and hold out_ready=0 for 4 cycles after the first out_valid.
  - Require in_ready=0 and out_data stable during the stall.
  - Require no drop or duplicate, and the order preserved on release.
- Bubbles: toggle in_valid 1,0,1,0 -> out_valid toggles 1,0,1,0 with 3-cycle offset; busy falls 1 cycle after the last output transfers.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 samples in flight. Require out_valid=0 and out_data=0 immediately (asynchronous), and no stale output after release.
- SIGMOID_DERIV_EN build: in_data 0 -> deriv_out 64; 256 or -256 -> 48; 2000 -> 0.
